// File: rtl/mcp3008_pkg.sv
// Shared types and constants for the MCP3008 SPI ADC responder.
// State enum, channel count, default result width and the debug view
// through which the FSM and synchronised pin levels are exposed.
package mcp3008_pkg;

  localparam int NUM_CH           = 8;
  localparam int DEFAULT_ADC_BITS = 10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    MODE,
    CH,
    SAMPLE,
    NULLB,
    DATA,
    TAIL
  } state_t;

  // Debug view: FSM state plus the synchronised pin levels it reacts to.
  typedef struct packed {
    state_t state;
    logic   armed;
    logic   cs_lvl;
    logic   sclk_lvl;
    logic   din_lvl;
    logic   din_toggle;
  } dbg_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous pin, with one-clk rise and
// fall pulses derived from the synchronised level. The reset value presets
// the whole chain so no spurious edge is reported as reset is released.
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the pin through the chain and remember the previous synced level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/mcp3008_responder.sv
// MCP3008 SPI slave model: decodes the start/SGL/D2..D0 command sampled on
// ad_clk rises, latches a result from ch_value, and shifts null bit plus
// result MSB-first on ad_clk falls. All pins are oversampled by clk.
// Optional build macro MCP3008_LSB_REPEAT_EN: after B0 the result is
// repeated LSB-first (B1..B(ADC_BITS-1)) before the trailing zeros.
//
// Pin protocol: cs low opens a frame, cs high ends it at any point
// (cs wins over a coincident ad_clk edge). din is sampled on synchronised
// ad_clk rise, dout changes one clk after the synchronised ad_clk fall.
module mcp3008_responder
  import mcp3008_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADC_BITS    = DEFAULT_ADC_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ad_clk,
  input  logic                       cs,
  input  logic                       din,
  output logic                       dout,
  output logic                       dout_oe,
  input  logic [NUM_CH*ADC_BITS-1:0] ch_value,
  output logic                       conv_valid,
  output logic                       conv_sgl,
  output logic [2:0]                 conv_ch,
  output logic [ADC_BITS-1:0]        conv_result,
  output dbg_t                       dbg
);

  localparam int CNT_W = $clog2(ADC_BITS + 1);
  localparam int FL_W  = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADC_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(ADC_BITS);
  localparam logic [CNT_W-1:0] CNT_D0   = CNT_W'(2);
  localparam logic [FL_W-1:0]  FL_DONE  = FL_W'(SYNC_STAGES);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic din_lvl, din_rise, din_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(ad_clk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
    .clk(clk), .rst_n(rst_n), .d(din),
    .level(din_lvl), .rise(din_rise), .fall(din_fall)
  );

  state_t             state, nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [1:0]         ch_sh;
  logic               sgl_cap;
  logic [FL_W-1:0]    flush_cnt;
  logic               armed;

  // Result selection: IN+ is always the addressed channel, IN- its pair.
  logic [ADC_BITS-1:0] ch_arr [NUM_CH];
  logic [2:0]          cmd_ch;
  logic [ADC_BITS-1:0] in_pos, in_neg, calc;

  // Unpack the flat channel bus into an indexable array.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      ch_arr[n] = ch_value[n*ADC_BITS +: ADC_BITS];
    end
  end

  assign cmd_ch = {ch_sh, din_lvl};
  assign in_pos = ch_arr[cmd_ch];
  assign in_neg = ch_arr[cmd_ch ^ 3'b001];
  assign calc   = sgl_cap ? in_pos : ((in_pos > in_neg) ? (in_pos - in_neg) : '0);

  // Arm only after the cs chain has flushed its preset and cs was seen high,
  // so a cs held low across reset cannot open a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else if (flush_cnt != FL_DONE) begin
      flush_cnt <= flush_cnt + 1'b1;
    end else if (cs_lvl) begin
      armed <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // FSM next-state: rises advance the command, falls advance the readout.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (armed && cs_fall)                 nxt = START;
      START:  if (sclk_rise && din_lvl)             nxt = MODE;
      MODE:   if (sclk_rise)                        nxt = CH;
      CH:     if (sclk_rise && bit_cnt == CNT_D0)   nxt = SAMPLE;
      SAMPLE: if (sclk_fall)                        nxt = NULLB;
      NULLB,
      DATA:   if (sclk_fall)                        nxt = (bit_cnt == '0) ? TAIL : DATA;
      TAIL:                                         nxt = TAIL;
      default:                                      nxt = IDLE;
    endcase
    if (cs_rise) nxt = IDLE;
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    dout_oe        = (state != IDLE);
    dbg.state      = state;
    dbg.armed      = armed;
    dbg.cs_lvl     = cs_lvl;
    dbg.sclk_lvl   = sclk_lvl;
    dbg.din_lvl    = din_lvl;
    dbg.din_toggle = din_rise | din_fall;
  end

  // Command capture, result latch and serial shift-out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      ch_sh       <= '0;
      sgl_cap     <= 1'b0;
      dout        <= 1'b0;
      conv_valid  <= 1'b0;
      conv_sgl    <= 1'b0;
      conv_ch     <= '0;
      conv_result <= '0;
    end else begin
      conv_valid <= 1'b0;
      if (cs_rise) begin
        bit_cnt <= '0;
        dout    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            dout    <= 1'b0;
          end
          MODE: if (sclk_rise) begin
            sgl_cap <= din_lvl;
            bit_cnt <= '0;
          end
          CH: if (sclk_rise) begin
            ch_sh   <= {ch_sh[0], din_lvl};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_D0) begin
              conv_valid  <= 1'b1;
              conv_sgl    <= sgl_cap;
              conv_ch     <= cmd_ch;
              conv_result <= calc;
              bit_cnt     <= CNT_LAST;
            end
          end
          SAMPLE: if (sclk_fall) dout <= 1'b0;
          NULLB, DATA: if (sclk_fall) begin
            dout    <= conv_result[bit_cnt];
            bit_cnt <= (bit_cnt == '0) ? CNT_W'(1) : bit_cnt - 1'b1;
          end
          TAIL: if (sclk_fall) begin
`ifdef MCP3008_LSB_REPEAT_EN
            if (bit_cnt < CNT_END) begin
              dout    <= conv_result[bit_cnt];
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              dout <= 1'b0;
            end
`else
            dout <= 1'b0;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcp3008_responder.sv
// Directed bench for mcp3008_responder: bit-banged SPI master frames with
// hand-computed command decodes, results and dout streams.
`timescale 1ns/1ps
module tb_mcp3008_responder;
  import mcp3008_pkg::*;

  localparam int AB   = 10;
  localparam int HALF = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ad_clk, cs, din;
  logic            dout, dout_oe;
  logic [8*AB-1:0] ch_value;
  logic            conv_valid, conv_sgl;
  logic [2:0]      conv_ch;
  logic [AB-1:0]   conv_result;
  dbg_t            dbg;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;

  mcp3008_responder #(.SYNC_STAGES(2), .ADC_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .ad_clk(ad_clk), .cs(cs), .din(din),
    .dout(dout), .dout_oe(dout_oe), .ch_value(ch_value),
    .conv_valid(conv_valid), .conv_sgl(conv_sgl), .conv_ch(conv_ch),
    .conv_result(conv_result), .dbg(dbg)
  );

  // clock / reset block
  always #10 clk = ~clk;

  always @(negedge clk) if (rst_n === 1'b1 && conv_valid === 1'b1) valid_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int n, input logic [AB-1:0] v);
    ch_value[n*AB +: AB] = v;
  endtask

  task automatic frame_begin();
    cs = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic frame_end();
    wait_clks(HALF);
    cs = 1'b1;
    wait_clks(10);
  endtask

  // One master clock per bit: din set while ad_clk low, dout sampled just before the rise.
  task automatic clock_bits(input logic [31:0] cmd, input int n_cmd, input int n_clk,
                            output logic [63:0] rx, output logic oe_all, output logic oe_any);
    rx = '0; oe_all = 1'b1; oe_any = 1'b0;
    for (int i = 0; i < n_clk; i++) begin
      din = (i < n_cmd) ? cmd[n_cmd-1-i] : 1'b0;
      wait_clks(HALF);
      rx = {rx[62:0], dout};
      if (dout_oe !== 1'b1) oe_all = 1'b0;
      if (dout_oe !== 1'b0) oe_any = 1'b1;
      ad_clk = 1'b1;
      wait_clks(HALF);
      ad_clk = 1'b0;
    end
    din = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs = 1'b1; ad_clk = 1'b0; din = 1'b0;
    wait_clks(3);
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b want 0", dout); end
    checks++; if (dout_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", dout_oe); end
    checks++; if (conv_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", conv_valid); end
    checks++; if (conv_sgl !== 1'b0) begin errors++; $display("FAIL reset_sgl: got %b want 0", conv_sgl); end
    checks++; if (conv_ch !== 3'd0) begin errors++; $display("FAIL reset_ch: got %0d want 0", conv_ch); end
    checks++; if (conv_result !== '0) begin errors++; $display("FAIL reset_result: got %0d want 0", conv_result); end
    checks++; if (dbg.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg.state, IDLE); end
    rst_n = 1'b1;
    wait_clks(10);
  endtask

  task automatic test_single_ended();
    logic [63:0] rx; logic oe_all, oe_any; int v0;
    v0 = valid_cnt;
    frame_begin();
    clock_bits(32'b11101, 5, 16, rx, oe_all, oe_any);
    frame_end();
    checks++; if (rx[15:0] !== 16'h02A5) begin errors++; $display("FAIL se_stream: got %h want 02a5", rx[15:0]); end
    checks++; if (oe_all !== 1'b1) begin errors++; $display("FAIL se_oe: got %b want 1", oe_all); end
    checks++; if (conv_ch !== 3'd5) begin errors++; $display("FAIL se_ch: got %0d want 5", conv_ch); end
    checks++; if (conv_sgl !== 1'b1) begin errors++; $display("FAIL se_sgl: got %b want 1", conv_sgl); end
    checks++; if (conv_result !== 10'h2A5) begin errors++; $display("FAIL se_result: got %h want 2a5", conv_result); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL se_valid_pulses: got %0d want 1", valid_cnt - v0); end
    checks++; if (dout_oe !== 1'b0) begin errors++; $display("FAIL se_oe_after_cs: got %b want 0", dout_oe); end
  endtask

  task automatic test_differential();
    logic [63:0] rx; logic oe_all, oe_any;
    frame_begin();
    clock_bits(32'b10010, 5, 16, rx, oe_all, oe_any);
    frame_end();
    checks++; if (conv_result !== 10'd400) begin errors++; $display("FAIL diff_result: got %0d want 400", conv_result); end
    checks++; if (rx[9:0] !== 10'd400) begin errors++; $display("FAIL diff_stream: got %0d want 400", rx[9:0]); end
    checks++; if (conv_sgl !== 1'b0 || conv_ch !== 3'd2) begin errors++; $display("FAIL diff_decode: got sgl=%b ch=%0d want sgl=0 ch=2", conv_sgl, conv_ch); end
    frame_begin();
    clock_bits(32'b10011, 5, 16, rx, oe_all, oe_any);
    frame_end();
    checks++; if (conv_result !== 10'd0) begin errors++; $display("FAIL diff_sat_result: got %0d want 0", conv_result); end
    checks++; if (rx[9:0] !== 10'd0) begin errors++; $display("FAIL diff_sat_stream: got %0d want 0", rx[9:0]); end
    checks++; if (conv_ch !== 3'd3) begin errors++; $display("FAIL diff_sat_ch: got %0d want 3", conv_ch); end
  endtask

  task automatic test_leading_zeros();
    logic [63:0] rx; logic oe_all, oe_any;
    frame_begin();
    clock_bits(32'b00011101, 8, 19, rx, oe_all, oe_any);
    frame_end();
    checks++; if (rx[10:0] !== 11'h2A5) begin errors++; $display("FAIL lz_stream: got %h want 2a5", rx[10:0]); end
    checks++; if (conv_ch !== 3'd5 || conv_sgl !== 1'b1) begin errors++; $display("FAIL lz_decode: got sgl=%b ch=%0d want sgl=1 ch=5", conv_sgl, conv_ch); end
    checks++; if (conv_result !== 10'h2A5) begin errors++; $display("FAIL lz_result: got %h want 2a5", conv_result); end
  endtask

  task automatic test_abort();
    logic [63:0] rx; logic oe_all, oe_any; int v0;
    set_ch(5, 10'h155);
    frame_begin();
    clock_bits(32'b11101, 5, 10, rx, oe_all, oe_any);
    cs = 1'b1;
    wait_clks(3);
    checks++; if (rx[3:0] !== 4'h5) begin errors++; $display("FAIL abort_partial: got %h want 5", rx[3:0]); end
    checks++; if (dout_oe !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b want 0", dout_oe); end
    checks++; if (dbg.state !== IDLE) begin errors++; $display("FAIL abort_state: got %0d want %0d", dbg.state, IDLE); end
    wait_clks(10);
    set_ch(5, 10'h2A5);
    frame_begin();
    clock_bits(32'b11101, 5, 16, rx, oe_all, oe_any);
    frame_end();
    checks++; if (rx[15:0] !== 16'h02A5) begin errors++; $display("FAIL abort_next_stream: got %h want 02a5", rx[15:0]); end
    // cs raised before D0: no conversion, result kept
    v0 = valid_cnt;
    set_ch(5, 10'h0F0);
    frame_begin();
    clock_bits(32'b111, 3, 3, rx, oe_all, oe_any);
    frame_end();
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL cmd_abort_valid: got %0d want 0", valid_cnt - v0); end
    checks++; if (conv_result !== 10'h2A5) begin errors++; $display("FAIL cmd_abort_result: got %h want 2a5", conv_result); end
    set_ch(5, 10'h2A5);
  endtask

  task automatic test_tail();
    logic [63:0] rx; logic oe_all, oe_any; logic [25:0] exp; logic [AB-1:0] v;
    v = 10'h2A5;
    exp = '0;
    for (int i = 0; i < 26; i++) begin
      int r;
      r = i + 1;
      if (r >= 7 && r <= 16) exp[25-i] = v[16-r];
`ifdef MCP3008_LSB_REPEAT_EN
      if (r >= 17 && r <= 25) exp[25-i] = v[r-16];
`endif
    end
    frame_begin();
    clock_bits(32'b11101, 5, 26, rx, oe_all, oe_any);
    frame_end();
    checks++; if (rx[25:0] !== exp) begin errors++; $display("FAIL tail_stream: got %h want %h", rx[25:0], exp); end
    checks++; if (oe_all !== 1'b1) begin errors++; $display("FAIL tail_oe: got %b want 1", oe_all); end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] rx; logic oe_all, oe_any; int v0;
    frame_begin();
    clock_bits(32'b11101, 5, 10, rx, oe_all, oe_any);
    rst_n = 1'b0;
    wait_clks(1);
    rst_n = 1'b1;
    checks++; if (dout_oe !== 1'b0 || dout !== 1'b0) begin errors++; $display("FAIL rmf_pins: got oe=%b dout=%b want 0 0", dout_oe, dout); end
    checks++; if (conv_result !== '0 || conv_ch !== 3'd0 || conv_sgl !== 1'b0) begin errors++; $display("FAIL rmf_conv: got res=%0d ch=%0d sgl=%b want 0 0 0", conv_result, conv_ch, conv_sgl); end
    checks++; if (dbg.state !== IDLE) begin errors++; $display("FAIL rmf_state: got %0d want %0d", dbg.state, IDLE); end
    v0 = valid_cnt;
    clock_bits(32'b11101, 5, 16, rx, oe_all, oe_any);
    checks++; if (oe_any !== 1'b0) begin errors++; $display("FAIL rmf_no_drive: got oe_any=%b want 0", oe_any); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL rmf_no_valid: got %0d want 0", valid_cnt - v0); end
    frame_end();
    frame_begin();
    clock_bits(32'b11101, 5, 16, rx, oe_all, oe_any);
    frame_end();
    checks++; if (rx[15:0] !== 16'h02A5) begin errors++; $display("FAIL rmf_next_stream: got %h want 02a5", rx[15:0]); end
    checks++; if (conv_result !== 10'h2A5) begin errors++; $display("FAIL rmf_next_result: got %h want 2a5", conv_result); end
  endtask

  initial begin
    for (int n = 0; n < 8; n++) ch_value[n*AB +: AB] = AB'(16*n + 3);
    set_ch(5, 10'h2A5);
    set_ch(2, 10'd700);
    set_ch(3, 10'd300);
    test_reset();
    test_single_ended();
    test_differential();
    test_leading_zeros();
    test_abort();
    test_tail();
    test_reset_mid_frame();
    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
